// File: rtl/moving_average_scheduler.sv
// Round-robin front end that time-shares one fixed-latency moving-average engine among N_CH
// requesters, routes results back by channel tag and tracks per-channel window warm-up.
module moving_average_scheduler #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned LAT    = 2,
    parameter int unsigned WINDOW = 4
) (
    input  logic                system1000,
    input  logic                system1000_rstn,
    input  logic [N_CH-1:0]     req_i,
    input  logic [8*N_CH-1:0]   sample_i,
    input  logic [N_CH-1:0]     ch_en_i,
    input  logic                clear_i,
    output logic [N_CH-1:0]     ack_o,
    output logic                eng_valid_o,
    output logic [7:0]          eng_sample_o,
    output logic [CH_W-1:0]     eng_ch_o,
    input  logic [7:0]          eng_result_i,
    output logic [N_CH-1:0]     res_valid_o,
    output logic [7:0]          res_data_o,
    output logic [N_CH-1:0]     warm_o
);

    localparam logic [7:0] WinCnt = 8'(WINDOW);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0] elig;
    logic            grant_vld;
    logic [CH_W-1:0] grant_ch;
    logic [7:0]      grant_sample;
    logic [7:0]      cnt_q [N_CH];
    logic [7:0]      cnt_d [N_CH];
    logic [N_CH-1:0] warm_d;
    logic [LAT-1:0]  tag_vld_q;
    logic [CH_W-1:0] tag_ch_q [LAT];
    logic [N_CH-1:0] res_valid_d;

    assign elig = req_i & ch_en_i;

    // Search starts at ptr and wraps; the first eligible channel wins.
    always_comb begin
        int unsigned s;
        s         = 0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            s = 32'(ptr_q) + i;
            if (s >= N_CH) s = s - N_CH;
            if (!grant_vld && elig[CH_W'(s)]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(s);
            end
        end
    end

    assign grant_sample = sample_i[{grant_ch, 3'b000} +: 8];

    always_comb begin
        ack_o = '0;
        if (grant_vld && system1000_rstn) ack_o[grant_ch] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (grant_vld) begin
            ptr_d = (32'(grant_ch) == N_CH - 1) ? '0 : grant_ch + 1'b1;
        end
    end

    // Clear wins over a same-cycle increment; the issue itself still goes ahead.
    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (clear_i) begin
                cnt_d[c] = '0;
            end else if (grant_vld && 32'(grant_ch) == c && cnt_q[c] != WinCnt) begin
                cnt_d[c] = cnt_q[c] + 8'd1;
            end
            warm_d[c] = (cnt_d[c] == WinCnt);
        end
    end

    always_comb begin
        res_valid_d = '0;
        if (tag_vld_q[LAT-1]) res_valid_d[tag_ch_q[LAT-1]] = 1'b1;
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            ptr_q        <= '0;
            eng_valid_o  <= 1'b0;
            eng_sample_o <= '0;
            eng_ch_o     <= '0;
            tag_vld_q    <= '0;
            tag_ch_q     <= '{default: '0};
            res_valid_o  <= '0;
            res_data_o   <= '0;
            cnt_q        <= '{default: '0};
            warm_o       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            eng_valid_o <= grant_vld;
            if (grant_vld) begin
                eng_sample_o <= grant_sample;
                eng_ch_o     <= grant_ch;
            end
            // Tags ride alongside the engine so each result knows its owner.
            tag_vld_q[0] <= eng_valid_o;
            tag_ch_q[0]  <= eng_ch_o;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_ch_q[i]  <= tag_ch_q[i-1];
            end
            res_valid_o <= res_valid_d;
            if (tag_vld_q[LAT-1]) res_data_o <= eng_result_i;
            cnt_q  <= cnt_d;
            warm_o <= warm_d;
        end
    end

endmodule

// File: tb/tb_moving_average_scheduler.sv
// Directed and randomized bench for moving_average_scheduler with an identity engine and a
// cycle-scheduled reference model of grants, results and warm-up.
module tb_moving_average_scheduler;

    localparam int N_CH   = 4;
    localparam int CH_W   = 2;
    localparam int LAT    = 2;
    localparam int WINDOW = 4;
    localparam int D      = LAT + 2;

    logic        system1000 = 1'b0;
    logic        system1000_rstn;
    logic [3:0]  req_i, ch_en_i;
    logic [31:0] sample_i;
    logic        clear_i;
    logic [3:0]  ack_o;
    logic        eng_valid_o;
    logic [7:0]  eng_sample_o;
    logic [1:0]  eng_ch_o;
    logic [7:0]  eng_result_i;
    logic [3:0]  res_valid_o;
    logic [7:0]  res_data_o;
    logic [3:0]  warm_o;

    int checks = 0;
    int errors = 0;

    moving_average_scheduler #(
        .N_CH(N_CH), .CH_W(CH_W), .LAT(LAT), .WINDOW(WINDOW)
    ) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .req_i           (req_i),
        .sample_i        (sample_i),
        .ch_en_i         (ch_en_i),
        .clear_i         (clear_i),
        .ack_o           (ack_o),
        .eng_valid_o     (eng_valid_o),
        .eng_sample_o    (eng_sample_o),
        .eng_ch_o        (eng_ch_o),
        .eng_result_i    (eng_result_i),
        .res_valid_o     (res_valid_o),
        .res_data_o      (res_data_o),
        .warm_o          (warm_o)
    );

    always #5 system1000 = ~system1000;

    // Identity engine: result is the sample seen LAT edges earlier.
    logic [7:0] eng_pipe [LAT];
    always @(posedge system1000) begin
        eng_pipe[0] <= eng_sample_o;
        for (int i = 1; i < LAT; i++) eng_pipe[i] <= eng_pipe[i-1];
    end
    assign eng_result_i = eng_pipe[LAT-1];

    // Reference model state
    int         m_ptr;
    int         m_cnt [N_CH];
    logic       m_ev;
    logic [7:0] m_es;
    int         m_ech;
    logic [7:0] m_rd;
    logic       s_v  [D];
    int         s_ch [D];
    logic [7:0] s_d  [D];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    function automatic int model_grant(input logic [3:0] e, input int p);
        for (int k = 0; k < N_CH; k++) begin
            if (e[(p + k) % N_CH]) return (p + k) % N_CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_ev  = 1'b0;
        m_es  = 8'h00;
        m_ech = 0;
        m_rd  = 8'h00;
        for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
        for (int i = 0; i < D; i++) begin
            s_v[i]  = 1'b0;
            s_ch[i] = 0;
            s_d[i]  = 8'h00;
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic [3:0] req, input logic [3:0] en, input logic [31:0] smp,
                        input logic clr);
        int         g;
        logic [3:0] exp_ack;
        logic [3:0] exp_rv;
        logic [3:0] exp_warm;
        req_i    = req;
        ch_en_i  = en;
        sample_i = smp;
        clear_i  = clr;
        #1;
        g       = model_grant(req & en, m_ptr);
        exp_ack = (g < 0) ? 4'b0000 : 4'(1 << g);
        chk("ack", 32'(ack_o), 32'(exp_ack));
        @(posedge system1000);
        #1;
        for (int i = 0; i < D - 1; i++) begin
            s_v[i]  = s_v[i+1];
            s_ch[i] = s_ch[i+1];
            s_d[i]  = s_d[i+1];
        end
        s_v[D-1] = 1'b0;
        m_ev     = (g >= 0);
        if (g >= 0) begin
            m_es      = smp[8*g +: 8];
            m_ech     = g;
            s_v[D-1]  = 1'b1;
            s_ch[D-1] = g;
            s_d[D-1]  = m_es;
        end
        if (s_v[0]) m_rd = s_d[0];
        if (clr) begin
            m_ptr = 0;
            for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N_CH;
            if (m_cnt[g] < WINDOW) m_cnt[g]++;
        end
        exp_rv = s_v[0] ? 4'(1 << s_ch[0]) : 4'b0000;
        for (int c = 0; c < N_CH; c++) exp_warm[c] = (m_cnt[c] == WINDOW);
        chk("eng_valid", 32'(eng_valid_o), 32'(m_ev));
        chk("eng_sample", 32'(eng_sample_o), 32'(m_es));
        chk("eng_ch", 32'(eng_ch_o), 32'(m_ech));
        chk("res_valid", 32'(res_valid_o), 32'(exp_rv));
        chk("res_data", 32'(res_data_o), 32'(m_rd));
        chk("warm", 32'(warm_o), 32'(exp_warm));
        @(negedge system1000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 4'hf, 32'h0, 1'b0);
    endtask

    initial begin
        logic [3:0]  r_req, r_en;
        logic [31:0] r_smp;
        logic        r_clr;

        // Power-on reset, with requests present to show ack is masked.
        system1000_rstn = 1'b0;
        req_i           = 4'hf;
        ch_en_i         = 4'hf;
        sample_i        = 32'h0;
        clear_i         = 1'b0;
        model_reset();
        repeat (3) @(negedge system1000);
        #1;
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_eng_valid", 32'(eng_valid_o), 32'h0);
        chk("rst_res_valid", 32'(res_valid_o), 32'h0);
        chk("rst_res_data", 32'(res_data_o), 32'h0);
        chk("rst_warm", 32'(warm_o), 32'h0);
        req_i = 4'h0;
        @(negedge system1000);
        system1000_rstn = 1'b1;

        // All four channels continuously, samples 10/20/30/40.
        for (int i = 0; i < 8; i++) step(4'hf, 4'hf, {8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
        idle(4);

        // Lone requester at or behind ptr.
        step(4'b0100, 4'hf, 32'h00_21_00_00, 1'b0);
        step(4'b0100, 4'hf, 32'h00_22_00_00, 1'b0);
        step(4'b0001, 4'hf, 32'h00_00_00_33, 1'b0);
        idle(1);

        // Channel 2 disabled.
        for (int i = 0; i < 6; i++) step(4'hf, 4'b1011, 32'h44_33_22_11, 1'b0);
        idle(2);

        // Warm-up on channel 1, then clear together with an issue.
        step(4'h0, 4'hf, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0010, 4'hf, 32'h0000_0500 + 32'(i << 8), 1'b0);
        idle(1);
        step(4'b0010, 4'hf, 32'h0000_0900, 1'b0);
        step(4'b0010, 4'hf, 32'h0000_0a00, 1'b0);
        idle(1);
        step(4'b0010, 4'hf, 32'h0000_0b00, 1'b1);
        idle(4);

        // Extremes back to back: ch3 = -128, ch0 = 127.
        step(4'b1000, 4'hf, 32'h80_00_00_7f, 1'b0);
        step(4'b0001, 4'hf, 32'h80_00_00_7f, 1'b0);
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r_req = 4'($urandom);
            r_en  = 4'($urandom | $urandom);
            r_smp = $urandom;
            r_clr = ($urandom_range(0, 15) == 0);
            step(r_req, r_en, r_smp, r_clr);
        end
        for (int i = 0; i < 6; i++) step(4'hf, 4'hf, $urandom, 1'b0);

        // Reset one cycle after a grant with -5 in flight.
        step(4'b0001, 4'hf, 32'h0000_00fb, 1'b0);
        system1000_rstn = 1'b0;
        req_i           = 4'hf;
        ch_en_i         = 4'hf;
        #1;
        chk("mid_rst_ack", 32'(ack_o), 32'h0);
        chk("mid_rst_eng_valid", 32'(eng_valid_o), 32'h0);
        chk("mid_rst_res_valid", 32'(res_valid_o), 32'h0);
        chk("mid_rst_warm", 32'(warm_o), 32'h0);
        model_reset();
        req_i = 4'h0;
        repeat (2) @(negedge system1000);
        system1000_rstn = 1'b1;
        idle(6);
        step(4'hf, 4'hf, 32'h04_03_02_01, 1'b0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
